// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing,
// memory handshake with timeout, and a retired-instruction counter.
module mips_mc_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             halt,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             instr_done,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // C_NONE covers j/jal/illegal: they never leave DECODE.
   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_R    = 3'd1,
      C_ADDI = 3'd2,
      C_ORI  = 3'd3,
      C_LW   = 3'd4,
      C_SW   = 3'd5,
      C_BEQ  = 3'd6
   } cls_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   cls_t             cls_q, cls_d;
   logic [2:0]       aop_q, aop_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q;

   cls_t       dec_cls;
   logic [2:0] dec_aop;
   logic       dec_j;
   logic       dec_jal;
   logic       dec_ill;
   logic [1:0] cls_srcb;
   logic       timeout;

   // Timeout fires on the last allowed waiting cycle; mem_ready wins.
   assign timeout = (wait_q == WAIT_LAST) && !mem_ready;

   assign retired_cnt = cnt_q;

   // Classify the parser fields and pick the ALU op used in EXEC/WB.
   always_comb begin
      dec_cls = C_NONE;
      dec_aop = 3'd0;
      dec_j   = 1'b0;
      dec_jal = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         6'h00: begin
            dec_cls = C_R;
            case (funct)
               6'h20:   dec_aop = 3'd0;
               6'h22:   dec_aop = 3'd1;
               6'h24:   dec_aop = 3'd2;
               6'h25:   dec_aop = 3'd3;
               6'h2A:   dec_aop = 3'd4;
               default: begin
                  dec_cls = C_NONE;
                  dec_ill = 1'b1;
               end
            endcase
         end
         6'h08: dec_cls = C_ADDI;
         6'h0D: begin
            dec_cls = C_ORI;
            dec_aop = 3'd3;
         end
         6'h23: dec_cls = C_LW;
         6'h2B: dec_cls = C_SW;
         6'h04: begin
            dec_cls = C_BEQ;
            dec_aop = 3'd1;
         end
         6'h02: dec_j = 1'b1;
         6'h03: begin
            dec_j   = 1'b1;
            dec_jal = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // ALU B source implied by the latched class.
   always_comb begin
      cls_srcb = 2'd0;
      case (cls_q)
         C_ADDI, C_LW, C_SW: cls_srcb = 2'd1;
         C_ORI:              cls_srcb = 2'd2;
         default:            cls_srcb = 2'd0;
      endcase
   end

   // Next-state, class latch and memory wait counter.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      aop_d   = aop_q;
      wait_d  = wait_q;
      unique case (state_q)
         S_FETCH: begin
            if (halt) begin
               wait_d = 8'd0;
            end else if (mem_ready) begin
               state_d = S_DECODE;
               wait_d  = 8'd0;
            end else if (timeout) begin
               wait_d = 8'd0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            cls_d   = dec_cls;
            aop_d   = dec_aop;
            wait_d  = 8'd0;
            state_d = (dec_cls == C_NONE) ? S_FETCH : S_EXEC;
         end
         S_EXEC: begin
            case (cls_q)
               C_LW, C_SW: begin
                  state_d = S_MEM;
                  wait_d  = 8'd0;
               end
               C_BEQ, C_NONE: state_d = S_FETCH;
               default:       state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
               wait_d  = 8'd0;
            end else if (timeout) begin
               state_d = S_FETCH;
               wait_d  = 8'd0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
         end
         default: begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
         end
      endcase
   end

   // Control outputs, all held low while reset is asserted.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      wb_sel     = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = 3'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            S_FETCH: begin
               if (!halt) begin
                  mem_read = 1'b1;
                  if (mem_ready) begin
                     ir_write = 1'b1;
                     pc_write = 1'b1;
                  end else if (timeout) begin
                     bus_err = 1'b1;
                  end
               end
            end
            S_DECODE: begin
               if (dec_j) begin
                  pc_write   = 1'b1;
                  pc_src     = 2'd2;
                  instr_done = 1'b1;
               end
               if (dec_jal) begin
                  reg_write = 1'b1;
                  reg_dst   = 2'd2;
                  wb_sel    = 2'd2;
               end
               illegal = dec_ill;
            end
            S_EXEC: begin
               alu_src_b = cls_srcb;
               alu_op    = aop_q;
               if (cls_q == C_BEQ) begin
                  pc_src     = 2'd1;
                  pc_write   = zero;
                  instr_done = 1'b1;
               end
            end
            S_MEM: begin
               mem_read  = (cls_q == C_LW);
               mem_write = (cls_q == C_SW);
               if (mem_ready) begin
                  instr_done = (cls_q == C_SW);
               end else if (timeout) begin
                  bus_err = 1'b1;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               reg_dst    = (cls_q == C_R) ? 2'd1 : 2'd0;
               wb_sel     = (cls_q == C_LW) ? 2'd1 : 2'd0;
               alu_src_b  = cls_srcb;
               alu_op     = aop_q;
            end
            default: begin
               mem_read = 1'b0;
            end
         endcase
      end
   end

   // State registers and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
         aop_q   <= 3'd0;
         wait_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         aop_q   <= aop_d;
         wait_q  <= wait_d;
         if (instr_done) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule
